demux1a2_cond_l2: RTL and testbench

- Receive-side counterpart of the level-2 2:1 valid-qualified byte mux.
- Takes the single byte stream in the clk_4f domain and un-interleaves it onto two lanes: lane 0, lane 1, lane 0, and so on.
- Each valid byte is steered by an internal lane-pointer state machine; both outputs are registered.
- Sits between the level-2 mux output and the level-1 demux stage, which consumes lane pairs.

---
 rtl/demux1a2_cond_l2_pkg.sv | 21 ++
 rtl/demux1a2_cond_l2_if.sv | 40 ++++
 rtl/demux1a2_cond_l2_lane_reg.sv | 37 +++
 rtl/demux1a2_cond_l2.sv | 95 +++++++++
 tb/tb_demux1a2_cond_l2.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/demux1a2_cond_l2_pkg.sv
// Shared definitions for the level-2 2:1 byte mux/demux family:
// default byte width, lane-pointer FSM encodings and a lane-advance helper.
package demux1a2_cond_l2_pkg;

    localparam int DEMUX_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_LANE0 = 1'b0,
        ST_LANE1 = 1'b1
    } lane_state_e;

    // Lane that follows the given one once a byte has been accepted.
    function automatic lane_state_e lane_advance(input lane_state_e cur);
        case (cur)
            ST_LANE0: lane_advance = ST_LANE1;
            ST_LANE1: lane_advance = ST_LANE0;
            default:  lane_advance = ST_LANE0;
        endcase
    endfunction

endpackage

// File: rtl/demux1a2_cond_l2_if.sv
// Byte-stream input and two-lane output bundle of the level-2 demux.
// slave: the demux itself; master: whoever feeds the stream and watches the lanes.
interface demux1a2_cond_l2_if
    import demux1a2_cond_l2_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
);

    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             valid0;
    logic [WIDTH-1:0] data_out0;
    logic             valid1;
    logic [WIDTH-1:0] data_out1;
    logic             pair_done;
    logic             lane_sel;

    modport master (
        output valid_in,
        output data_in,
        input  valid0,
        input  data_out0,
        input  valid1,
        input  data_out1,
        input  pair_done,
        input  lane_sel
    );

    modport slave (
        input  valid_in,
        input  data_in,
        output valid0,
        output data_out0,
        output valid1,
        output data_out1,
        output pair_done,
        output lane_sel
    );

endinterface

// File: rtl/demux1a2_cond_l2_lane_reg.sv
// One output lane: a load-enabled data register plus a valid flop.
// Data holds between loads; valid is high only in the cycle after a load.
module demux1a2_cond_l2_lane_reg
    import demux1a2_cond_l2_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;

    // Capture the byte on load, otherwise hold; valid mirrors the load of the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else begin
            valid_r <= load;
            if (load) begin
                data_r <= d;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign q     = data_r;
    assign valid = valid_r;

endmodule

// File: rtl/demux1a2_cond_l2.sv
// Level-2 2:1 byte demux: un-interleaves a valid-qualified byte stream onto
// lane 0 / lane 1 alternately. Idle cycles never disturb lane alignment.
module demux1a2_cond_l2
    import demux1a2_cond_l2_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic                clk_4f,
    input  logic                reset_L,
    demux1a2_cond_l2_if.slave   bus
);

    lane_state_e      state_r;
    lane_state_e      state_nxt_s;
    logic             load0_s;
    logic             load1_s;
    logic             pair_done_r;
    logic [WIDTH-1:0] data0_s;
    logic [WIDTH-1:0] data1_s;
    logic             valid0_s;
    logic             valid1_s;

    // Lane-pointer state register.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_r <= ST_LANE0;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Advance the pointer only on an accepted byte.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.valid_in) begin
            state_nxt_s = lane_advance(state_r);
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Decode per-lane load enables from the pointer and valid_in.
    always_comb begin
        load0_s = 1'b0;
        load1_s = 1'b0;
        if (bus.valid_in) begin
            case (state_r)
                ST_LANE0: load0_s = 1'b1;
                ST_LANE1: load1_s = 1'b1;
                default: begin
                    load0_s = 1'b0;
                    load1_s = 1'b0;
                end
            endcase
        end else begin
            load0_s = 1'b0;
            load1_s = 1'b0;
        end
    end

    // A lane-1 load always closes a pair, so pair_done tracks valid1.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            pair_done_r <= 1'b0;
        end else begin
            pair_done_r <= load1_s;
        end
    end

    demux1a2_cond_l2_lane_reg #(.WIDTH(WIDTH)) u_lane0 (
        .clk   (clk_4f),
        .rst_n (reset_L),
        .load  (load0_s),
        .d     (bus.data_in),
        .q     (data0_s),
        .valid (valid0_s)
    );

    demux1a2_cond_l2_lane_reg #(.WIDTH(WIDTH)) u_lane1 (
        .clk   (clk_4f),
        .rst_n (reset_L),
        .load  (load1_s),
        .d     (bus.data_in),
        .q     (data1_s),
        .valid (valid1_s)
    );

    assign bus.valid0    = valid0_s;
    assign bus.data_out0 = data0_s;
    assign bus.valid1    = valid1_s;
    assign bus.data_out1 = data1_s;
    assign bus.pair_done = pair_done_r;
    assign bus.lane_sel  = state_r;

endmodule

// File: tb/tb_demux1a2_cond_l2.sv
// Self-checking bench for demux1a2_cond_l2: directed vector table, hand-written
// reset/gap sequences and a random stream checked against a lane-parity model.
module tb_demux1a2_cond_l2;

    logic clk_4f;
    logic reset_L;
    int   tests;
    int   fails;

    demux1a2_cond_l2_if #(.WIDTH(8)) bus_if ();

    demux1a2_cond_l2 #(.WIDTH(8)) dut (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .bus     (bus_if)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic       vin;
        logic [7:0] din;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       pd;
        logic       ls;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v0, input logic [7:0] d0,
                             input logic v1, input logic [7:0] d1,
                             input logic pd, input logic ls);
        check({tag, " valid0"},    {31'd0, bus_if.valid0},    {31'd0, v0});
        check({tag, " data_out0"}, {24'd0, bus_if.data_out0}, {24'd0, d0});
        check({tag, " valid1"},    {31'd0, bus_if.valid1},    {31'd0, v1});
        check({tag, " data_out1"}, {24'd0, bus_if.data_out1}, {24'd0, d1});
        check({tag, " pair_done"}, {31'd0, bus_if.pair_done}, {31'd0, pd});
        check({tag, " lane_sel"},  {31'd0, bus_if.lane_sel},  {31'd0, ls});
        check({tag, " exclusive"}, {31'd0, bus_if.valid0 & bus_if.valid1}, 32'd0);
    endtask

    // Drive one cycle of input, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] d);
        bus_if.valid_in = v;
        bus_if.data_in  = d;
        @(posedge clk_4f);
        #1;
    endtask

    // Asynchronous reset pulse placed away from any clock edge.
    task automatic reset_pulse();
        #2;
        reset_L = 1'b0;
        #2;
        reset_L = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_q [$];
        logic [7:0] d;
        logic [7:0] got;
        logic       v;
        int         n_acc;
        int         pairs;
        int         lane;

        tests = 0;
        fails = 0;
        reset_L = 1'b0;
        bus_if.valid_in = 1'b0;
        bus_if.data_in  = 8'h00;
        #12;
        reset_L = 1'b1;

        // 1. asynchronous reset with an active byte on the input
        step(1'b1, 8'h77);
        check_all("pre_reset", 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1);
        #3;
        bus_if.valid_in = 1'b1;
        bus_if.data_in  = 8'hFF;
        reset_L = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        bus_if.valid_in = 1'b0;
        reset_L = 1'b1;

        // 2/3. alternation and gaps (idle bytes carry X)
        vecs[0] = '{1'b1, 8'hA1, 1'b1, 8'hA1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'hB2, 1'b0, 8'hA1, 1'b1, 8'hB2, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'hC3, 1'b1, 8'hC3, 1'b0, 8'hB2, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'hD4, 1'b0, 8'hC3, 1'b1, 8'hD4, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h11, 1'b1, 8'h11, 1'b0, 8'hD4, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'hxx, 1'b0, 8'h11, 1'b0, 8'hD4, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'hxx, 1'b0, 8'h11, 1'b0, 8'hD4, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'h22, 1'b0, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].vin, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i].v0, vecs[i].d0,
                      vecs[i].v1, vecs[i].d1, vecs[i].pd, vecs[i].ls);
        end

        // 4. odd count then a long gap keeps the pointer on lane 1
        step(1'b1, 8'h5A);
        check_all("odd_5A", 1'b1, 8'h5A, 1'b0, 8'h22, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'hxx);
            check($sformatf("gap%0d lane_sel", i), {31'd0, bus_if.lane_sel}, 32'd1);
            check($sformatf("gap%0d valids", i), {30'd0, bus_if.valid0, bus_if.valid1}, 32'd0);
        end
        step(1'b1, 8'h6B);
        check_all("after_gap_6B", 1'b0, 8'h5A, 1'b1, 8'h6B, 1'b1, 1'b0);

        // 5. reset mid-pair discards the half pair
        step(1'b1, 8'h33);
        check_all("mid_33", 1'b1, 8'h33, 1'b0, 8'h6B, 1'b0, 1'b1);
        bus_if.valid_in = 1'b0;
        reset_pulse();
        check_all("mid_reset", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h44);
        check_all("mid_44", 1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'hxx);
        check_all("mid_idle", 1'b0, 8'h44, 1'b0, 8'h00, 1'b0, 1'b1);

        // 6. random stream: lane of the k-th accepted byte is k mod 2
        bus_if.valid_in = 1'b0;
        reset_pulse();
        exp_q.delete();
        n_acc = 0;
        pairs = 0;
        for (int i = 0; i < 1000; i++) begin
            v = 1'($urandom_range(0, 1));
            d = v ? 8'($urandom_range(0, 255)) : 8'hxx;
            lane = n_acc % 2;
            if (v) begin
                exp_q.push_back(d);
                n_acc++;
            end
            step(v, d);
            check("rnd valid0", {31'd0, bus_if.valid0}, {31'd0, (v && lane == 0)});
            check("rnd valid1", {31'd0, bus_if.valid1}, {31'd0, (v && lane == 1)});
            check("rnd pair_done", {31'd0, bus_if.pair_done}, {31'd0, (v && lane == 1)});
            check("rnd lane_sel", {31'd0, bus_if.lane_sel}, 32'(n_acc % 2));
            if (bus_if.valid0 === 1'b1 || bus_if.valid1 === 1'b1) begin
                got = (bus_if.valid0 === 1'b1) ? bus_if.data_out0 : bus_if.data_out1;
                if (exp_q.size() == 0) begin
                    check("rnd scoreboard underflow", 32'd1, 32'd0);
                end else begin
                    check("rnd merged data", {24'd0, got}, {24'd0, exp_q.pop_front()});
                end
            end
            if (bus_if.pair_done === 1'b1) begin
                pairs++;
            end
        end
        check("rnd pair count", 32'(pairs), 32'(n_acc / 2));
        check("rnd leftover bytes", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
